multi_proxy_recompute_controller: RTL and testbench
===================================================

Name: multi_proxy_recompute_controller

Overview:
- Per-column BISR recompute controller; successor to the single-proxy column controller.
- Assigns up to NUM_PROXIES proxy PEs to faulty rows of one systolic-array column, based on the STW (stuck-at/weight test) result vector.
- Loads each proxy's stationary weight in turn, then places all assigned proxies in matmul mode.
- Flags faults that cannot be covered. Re-arms on a weight reload so a new tile gets fresh assignments.

Parameters:
- ROWS, 4, PEs per column; ROW_WIDTH = $clog2(ROWS).
- WORD_SIZE, 16, data/weight width.
- NUM_PROXIES, 2, proxy PEs available to this column (1..ROWS); SLOT_WIDTH = max(1, $clog2(NUM_PROXIES)).
- COL_IDX, 0, column served; informational only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- STW_complete  in  1  STW result valid this cycle.
- STW_result_mat  in  ROWS  1 = row passed, 0 = row faulty.
- weight_reload  in  1  pulse: new weights are being loaded; drop all assignments.
- rcm_in_weight  in  WORD_SIZE  weight of row rcm_idx_sel (external mux).
- rcm_left_in  in  WORD_SIZE  activation stream for the proxies.
- rcm_idx_sel  out  ROW_WIDTH  row select for the external weight mux.
- proxy_sel  out  NUM_PROXIES  one-hot proxy currently being loaded.
- proxy_row_idx  out  NUM_PROXIES*ROW_WIDTH  row covered by each proxy; slot k at bits [k*ROW_WIDTH +: ROW_WIDTH].
- proxy_en  out  ROWS  mask of covered (bypassed) rows.
- load_proxy  out  1  proxy weight-load strobe.
- proxy_matmul  out  1  proxies in compute mode.
- proxy_settings  out  3  {stat_bit, fsm_out_select, fsm_op2_select}.
- rcm_weight  out  WORD_SIZE  weight driven to the selected proxy.
- proxy_left_in  out  WORD_SIZE  rcm_left_in delayed 1 cycle.
- proxy_out_valid  out  1  proxy output valid.
- fault_count  out  $clog2(ROWS+1)  popcount of the latched fault mask.
- uncovered_fault  out  1  more faults than proxies.
- busy  out  1  state is SCAN, LOAD1 or LOAD2.

Behaviour:
- Reset: all outputs 0; state IDLE; internal fault_mask, pending, covered, slot, cur_idx all cleared.
- States: IDLE, SCAN, LOAD1, LOAD2, COMPUTE.
- IDLE:
  - On STW_complete, latch fault_mask = ~STW_result_mat and pending = fault_mask; set fault_count.
  - If the mask is nonzero, go to SCAN; otherwise stay in IDLE.
  - STW_result_mat is ignored when STW_complete = 0.
- SCAN (1 cycle): cur_idx = lowest set bit of pending; slot unchanged; go to LOAD1.
- LOAD1:
  - rcm_weight <= rcm_in_weight; proxy_settings <= 3'b001; load_proxy <= 1; proxy_sel = 1<<slot.
  - Go to LOAD2.
- LOAD2:
  - rcm_weight <= rcm_in_weight (weight held two cycles); proxy_settings <= 3'b001.
  - Clear cur_idx in pending; set cur_idx in covered; proxy_row_idx[slot] <= cur_idx.
  - If pending (after the clear) is nonzero and slot < NUM_PROXIES-1: slot++, go to SCAN.
  - Otherwise go to COMPUTE.
- COMPUTE:
  - rcm_weight <= 0; load_proxy <= 0; proxy_matmul <= 1; proxy_settings <= 3'b110.
  - Hold until weight_reload. STW_complete is ignored here.
- Combinational outputs:
  - rcm_idx_sel = cur_idx.
  - proxy_en = covered.
  - uncovered_fault = (state == COMPUTE) && |(fault_mask & ~covered).
- weight_reload, any state:
  - Next state IDLE; clear masks, slot, outputs and proxy_row_idx.
  - Takes priority over STW_complete in the same cycle.
  - If STW_complete and weight_reload are both high in IDLE, reload wins and STW is dropped.
- Left-input pipeline:
  - proxy_left_in <= rcm_left_in every cycle.
  - proxy_out_valid <= proxy_matmul && (proxy_left_in != 0).
- Timing:
  - Load latency per proxy is 3 cycles (SCAN, LOAD1, LOAD2).
  - proxy_matmul rises 3*min(faults, NUM_PROXIES)+1 cycles after the STW_complete edge.
- Mid-operation rst: returns to IDLE with everything cleared, the same as at power-up.

Test Plan:
- No fault: STW_result_mat=4'b1111 with STW_complete -> state stays IDLE; proxy_en=0, fault_count=0, proxy_matmul never asserts.
- Single fault: STW_result_mat=4'b1011, weight row2=16'h00A5.
  - rcm_idx_sel=2 during LOAD1; rcm_weight=16'h00A5 for 2 cycles; proxy_sel=2'b01.
  - Then proxy_settings=3'b110, proxy_en=4'b0100, fault_count=1, uncovered_fault=0.
- Two faults: STW_result_mat=4'b0110 -> row0 loaded into slot0, then row3 into slot1.
  - proxy_row_idx={2'd3,2'd0}, proxy_en=4'b1001.
  - proxy_matmul high exactly 7 cycles after STW_complete.
- Overflow: NUM_PROXIES=2, STW_result_mat=4'b0000 -> rows 0 and 1 covered, fault_count=4, uncovered_fault=1 in COMPUTE.
- Reload:
  - weight_reload pulse during LOAD2 -> IDLE next cycle with all outputs 0.
  - A new STW with 4'b1110 then covers row0 only.
  - STW_complete and weight_reload in the same cycle -> remains IDLE.
- Valid pipeline: in COMPUTE drive rcm_left_in 0,7,0,3 -> proxy_left_in lags 1 cycle; proxy_out_valid lags 2 cycles with pattern 0,1,0,1.

Source files
------------

// File: rtl/multi_proxy_recompute_controller_if.sv
// Bus bundle between a systolic-array column and its proxy recompute
// controller: STW results, weight/activation feeds and proxy control.
interface multi_proxy_recompute_controller_if #(
  parameter int ROWS        = 4,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PROXIES = 2
);
  localparam int ROW_WIDTH = $clog2(ROWS);
  localparam int CNT_WIDTH = $clog2(ROWS + 1);

  // Column / test side
  logic                              STW_complete;
  logic [ROWS-1:0]                   STW_result_mat;
  logic                              weight_reload;
  logic [WORD_SIZE-1:0]              rcm_in_weight;
  logic [WORD_SIZE-1:0]              rcm_left_in;

  // Controller side
  logic [ROW_WIDTH-1:0]              rcm_idx_sel;
  logic [NUM_PROXIES-1:0]            proxy_sel;
  logic [NUM_PROXIES*ROW_WIDTH-1:0]  proxy_row_idx;
  logic [ROWS-1:0]                   proxy_en;
  logic                              load_proxy;
  logic                              proxy_matmul;
  logic [2:0]                        proxy_settings;
  logic [WORD_SIZE-1:0]              rcm_weight;
  logic [WORD_SIZE-1:0]              proxy_left_in;
  logic                              proxy_out_valid;
  logic [CNT_WIDTH-1:0]              fault_count;
  logic                              uncovered_fault;
  logic                              busy;

  modport master (
    output STW_complete, STW_result_mat, weight_reload, rcm_in_weight, rcm_left_in,
    input  rcm_idx_sel, proxy_sel, proxy_row_idx, proxy_en, load_proxy, proxy_matmul,
           proxy_settings, rcm_weight, proxy_left_in, proxy_out_valid, fault_count,
           uncovered_fault, busy
  );

  modport slave (
    input  STW_complete, STW_result_mat, weight_reload, rcm_in_weight, rcm_left_in,
    output rcm_idx_sel, proxy_sel, proxy_row_idx, proxy_en, load_proxy, proxy_matmul,
           proxy_settings, rcm_weight, proxy_left_in, proxy_out_valid, fault_count,
           uncovered_fault, busy
  );
endinterface

// File: rtl/multi_proxy_recompute_controller.sv
// Per-column BISR recompute controller. Assigns up to NUM_PROXIES proxy PEs
// to the lowest-numbered faulty rows reported by the STW, loads each proxy's
// stationary weight in turn (SCAN/LOAD1/LOAD2), then runs them in matmul mode.
module multi_proxy_recompute_controller #(
  parameter int ROWS        = 4,
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PROXIES = 2,
  parameter int COL_IDX     = 0
) (
  input logic                                clk,
  input logic                                rst,
  multi_proxy_recompute_controller_if.slave  bus
);

  localparam int ROW_WIDTH  = $clog2(ROWS);
  localparam int SLOT_WIDTH = (NUM_PROXIES > 1) ? $clog2(NUM_PROXIES) : 1;
  localparam int CNT_WIDTH  = $clog2(ROWS + 1);
  localparam int IDX_WIDTH  = NUM_PROXIES * ROW_WIDTH;

  localparam logic [SLOT_WIDTH-1:0]  LAST_SLOT = SLOT_WIDTH'(NUM_PROXIES - 1);
  localparam logic [ROWS-1:0]        ROW_ONE   = ROWS'(1);
  localparam logic [NUM_PROXIES-1:0] SLOT_ONE  = NUM_PROXIES'(1);

  // Reject parameter sets the slot/row encoding cannot represent.
  if (NUM_PROXIES < 1 || NUM_PROXIES > ROWS || ROWS < 2 || COL_IDX < 0) begin : g_bad_params
    $error("multi_proxy_recompute_controller: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, SCAN, LOAD1, LOAD2, COMPUTE} state_t;

  state_t                 state_q, state_d;
  logic [ROWS-1:0]        fault_mask_q, fault_mask_d;
  logic [ROWS-1:0]        pending_q, pending_d;
  logic [ROWS-1:0]        covered_q, covered_d;
  logic [SLOT_WIDTH-1:0]  slot_q, slot_d;
  logic [ROW_WIDTH-1:0]   cur_idx_q, cur_idx_d;
  logic [NUM_PROXIES-1:0] proxy_sel_q, proxy_sel_d;
  logic [IDX_WIDTH-1:0]   row_idx_q, row_idx_d;
  logic                   load_proxy_q, load_proxy_d;
  logic                   proxy_matmul_q, proxy_matmul_d;
  logic [2:0]             settings_q, settings_d;
  logic [WORD_SIZE-1:0]   rcm_weight_q, rcm_weight_d;
  logic [WORD_SIZE-1:0]   left_in_q, left_in_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0]   fault_count_q, fault_count_d;

  logic [ROWS-1:0]        stw_faults;
  logic [ROWS-1:0]        cur_bit;
  logic [ROWS-1:0]        pending_clr;
  logic [NUM_PROXIES-1:0] slot_hit;

  function automatic logic [ROW_WIDTH-1:0] lowest_set(input logic [ROWS-1:0] v);
    lowest_set = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = ROW_WIDTH'(i);
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [ROWS-1:0] v);
    popcount = '0;
    for (int i = 0; i < ROWS; i++) begin
      popcount = popcount + CNT_WIDTH'(v[i]);
    end
  endfunction

  assign stw_faults  = ~bus.STW_result_mat;
  assign cur_bit     = ROW_ONE << cur_idx_q;
  assign pending_clr = pending_q & ~cur_bit;

  // One decode line per proxy slot, used to steer the row index write.
  for (genvar gi = 0; gi < NUM_PROXIES; gi++) begin : g_slot
    assign slot_hit[gi] = (slot_q == SLOT_WIDTH'(gi));
  end

  // Next-state and registered-output logic; every _d defaults to hold.
  always_comb begin
    state_d        = state_q;
    fault_mask_d   = fault_mask_q;
    pending_d      = pending_q;
    covered_d      = covered_q;
    slot_d         = slot_q;
    cur_idx_d      = cur_idx_q;
    proxy_sel_d    = proxy_sel_q;
    row_idx_d      = row_idx_q;
    load_proxy_d   = load_proxy_q;
    proxy_matmul_d = proxy_matmul_q;
    settings_d     = settings_q;
    rcm_weight_d   = rcm_weight_q;
    fault_count_d  = fault_count_q;
    // The activation pipeline runs regardless of controller state.
    left_in_d      = bus.rcm_left_in;
    out_valid_d    = proxy_matmul_q && (left_in_q != '0);

    if (bus.weight_reload) begin
      // New tile: forget every assignment, STW in the same cycle is dropped.
      state_d        = IDLE;
      fault_mask_d   = '0;
      pending_d      = '0;
      covered_d      = '0;
      slot_d         = '0;
      cur_idx_d      = '0;
      proxy_sel_d    = '0;
      row_idx_d      = '0;
      load_proxy_d   = 1'b0;
      proxy_matmul_d = 1'b0;
      settings_d     = 3'b000;
      rcm_weight_d   = '0;
      fault_count_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.STW_complete) begin
            fault_mask_d  = stw_faults;
            pending_d     = stw_faults;
            fault_count_d = popcount(stw_faults);
            if (stw_faults != '0) state_d = SCAN;
          end
        end
        SCAN: begin
          cur_idx_d = lowest_set(pending_q);
          state_d   = LOAD1;
        end
        LOAD1: begin
          rcm_weight_d = bus.rcm_in_weight;
          settings_d   = 3'b001;
          load_proxy_d = 1'b1;
          proxy_sel_d  = SLOT_ONE << slot_q;
          state_d      = LOAD2;
        end
        LOAD2: begin
          // Weight is presented for a second cycle while the proxy latches it.
          rcm_weight_d = bus.rcm_in_weight;
          settings_d   = 3'b001;
          pending_d    = pending_clr;
          covered_d    = covered_q | cur_bit;
          for (int k = 0; k < NUM_PROXIES; k++) begin
            if (slot_hit[k]) row_idx_d[k*ROW_WIDTH +: ROW_WIDTH] = cur_idx_q;
          end
          if ((pending_clr != '0) && (slot_q < LAST_SLOT)) begin
            slot_d  = slot_q + SLOT_WIDTH'(1);
            state_d = SCAN;
          end else begin
            state_d = COMPUTE;
          end
        end
        COMPUTE: begin
          rcm_weight_d   = '0;
          load_proxy_d   = 1'b0;
          proxy_sel_d    = '0;
          proxy_matmul_d = 1'b1;
          settings_d     = 3'b110;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      fault_mask_q   <= '0;
      pending_q      <= '0;
      covered_q      <= '0;
      slot_q         <= '0;
      cur_idx_q      <= '0;
      proxy_sel_q    <= '0;
      row_idx_q      <= '0;
      load_proxy_q   <= 1'b0;
      proxy_matmul_q <= 1'b0;
      settings_q     <= 3'b000;
      rcm_weight_q   <= '0;
      left_in_q      <= '0;
      out_valid_q    <= 1'b0;
      fault_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      fault_mask_q   <= fault_mask_d;
      pending_q      <= pending_d;
      covered_q      <= covered_d;
      slot_q         <= slot_d;
      cur_idx_q      <= cur_idx_d;
      proxy_sel_q    <= proxy_sel_d;
      row_idx_q      <= row_idx_d;
      load_proxy_q   <= load_proxy_d;
      proxy_matmul_q <= proxy_matmul_d;
      settings_q     <= settings_d;
      rcm_weight_q   <= rcm_weight_d;
      left_in_q      <= left_in_d;
      out_valid_q    <= out_valid_d;
      fault_count_q  <= fault_count_d;
    end
  end

  assign bus.rcm_idx_sel     = cur_idx_q;
  assign bus.proxy_sel       = proxy_sel_q;
  assign bus.proxy_row_idx   = row_idx_q;
  assign bus.proxy_en        = covered_q;
  assign bus.load_proxy      = load_proxy_q;
  assign bus.proxy_matmul    = proxy_matmul_q;
  assign bus.proxy_settings  = settings_q;
  assign bus.rcm_weight      = rcm_weight_q;
  assign bus.proxy_left_in   = left_in_q;
  assign bus.proxy_out_valid = out_valid_q;
  assign bus.fault_count     = fault_count_q;
  assign bus.uncovered_fault = (state_q == COMPUTE) && ((fault_mask_q & ~covered_q) != '0);
  assign bus.busy            = (state_q == SCAN) || (state_q == LOAD1) || (state_q == LOAD2);

endmodule

// File: tb/tb_multi_proxy_recompute_controller.sv
// Randomized bench for the multi-proxy recompute controller. Expected values
// come from a tile-level model: faulty rows sorted ascending, the first
// NUM_PROXIES of them get proxies, each proxy costs three cycles.
module tb_multi_proxy_recompute_controller;
  localparam int ROWS        = 4;
  localparam int WORD_SIZE   = 16;
  localparam int NUM_PROXIES = 2;
  localparam int ROW_WIDTH   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_proxy_recompute_controller_if #(
    .ROWS(ROWS), .WORD_SIZE(WORD_SIZE), .NUM_PROXIES(NUM_PROXIES)
  ) bus ();

  multi_proxy_recompute_controller #(
    .ROWS(ROWS), .WORD_SIZE(WORD_SIZE), .NUM_PROXIES(NUM_PROXIES), .COL_IDX(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // External weight mux of the column.
  logic [WORD_SIZE-1:0] wmem [ROWS];
  assign bus.rcm_in_weight = wmem[bus.rcm_idx_sel];

  int n_vectors     = 0;
  int n_miscompares = 0;
  logic [WORD_SIZE-1:0] left_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic randomize_weights();
    for (int i = 0; i < ROWS; i++) wmem[i] = WORD_SIZE'($urandom);
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "/idx_sel"},   bus.rcm_idx_sel, 0);
    check_eq({tag, "/proxy_sel"}, bus.proxy_sel, 0);
    check_eq({tag, "/row_idx"},   bus.proxy_row_idx, 0);
    check_eq({tag, "/en"},        bus.proxy_en, 0);
    check_eq({tag, "/load"},      bus.load_proxy, 0);
    check_eq({tag, "/matmul"},    bus.proxy_matmul, 0);
    check_eq({tag, "/settings"},  bus.proxy_settings, 0);
    check_eq({tag, "/weight"},    bus.rcm_weight, 0);
    check_eq({tag, "/left_in"},   bus.proxy_left_in, 0);
    check_eq({tag, "/valid"},     bus.proxy_out_valid, 0);
    check_eq({tag, "/fcount"},    bus.fault_count, 0);
    check_eq({tag, "/uncov"},     bus.uncovered_fault, 0);
    check_eq({tag, "/busy"},      bus.busy, 0);
  endtask

  task automatic reload_and_check(input string tag);
    bus.rcm_left_in   = '0;
    bus.weight_reload = 1'b1;
    @(negedge clk);
    bus.weight_reload = 1'b0;
    check_cleared(tag);
  endtask

  // Issue one STW result and follow the whole proxy assignment sequence.
  // Called at a negedge with the controller idle.
  task automatic run_tile(input logic [ROWS-1:0] pass, output int k_out);
    logic [ROWS-1:0]                  fmask;
    logic [ROWS-1:0]                  exp_en;
    logic [NUM_PROXIES*ROW_WIDTH-1:0] exp_idx;
    int rows_q [$];
    int k, last, j, ph;
    fmask   = ~pass;
    exp_en  = '0;
    exp_idx = '0;
    for (int i = 0; i < ROWS; i++) if (fmask[i]) rows_q.push_back(i);
    k = (rows_q.size() < NUM_PROXIES) ? rows_q.size() : NUM_PROXIES;
    for (int s = 0; s < k; s++) begin
      exp_en[rows_q[s]] = 1'b1;
      exp_idx[s*ROW_WIDTH +: ROW_WIDTH] = ROW_WIDTH'(rows_q[s]);
    end
    $display("tile pass=%b faults=%0d proxies=%0d w=%h,%h,%h,%h", pass, rows_q.size(), k,
             wmem[0], wmem[1], wmem[2], wmem[3]);
    bus.STW_complete   = 1'b1;
    bus.STW_result_mat = pass;
    last = (k == 0) ? 6 : 3 * k + 1;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      if (n == 0) begin
        bus.STW_complete = 1'b0;
        bus.STW_result_mat = ROWS'($urandom);
        check_eq("fault_count", bus.fault_count, rows_q.size());
      end
      if (k == 0) begin
        check_eq("nofault/matmul", bus.proxy_matmul, 0);
        check_eq("nofault/busy", bus.busy, 0);
        check_eq("nofault/en", bus.proxy_en, 0);
      end else if (n >= 1 && n <= 3 * k) begin
        j  = (n - 1) / 3;
        ph = (n - 1) % 3;
        if (ph == 0) begin
          check_eq("idx_sel", bus.rcm_idx_sel, rows_q[j]);
          check_eq("busy", bus.busy, 1);
        end else if (ph == 1) begin
          check_eq("weight1", bus.rcm_weight, wmem[rows_q[j]]);
          check_eq("load", bus.load_proxy, 1);
          check_eq("proxy_sel", bus.proxy_sel, 1 << j);
          check_eq("settings_load", bus.proxy_settings, 3'b001);
        end else begin
          check_eq("weight2", bus.rcm_weight, wmem[rows_q[j]]);
        end
        if (n == 3 * k) check_eq("matmul_early", bus.proxy_matmul, 0);
      end
    end
    if (k > 0) begin
      check_eq("matmul", bus.proxy_matmul, 1);
      check_eq("settings_cmp", bus.proxy_settings, 3'b110);
      check_eq("en", bus.proxy_en, exp_en);
      check_eq("row_idx", bus.proxy_row_idx, exp_idx);
      check_eq("fault_count_c", bus.fault_count, rows_q.size());
      check_eq("uncovered", bus.uncovered_fault, rows_q.size() > NUM_PROXIES);
      check_eq("load_off", bus.load_proxy, 0);
      check_eq("weight_off", bus.rcm_weight, 0);
      check_eq("busy_off", bus.busy, 0);
    end else begin
      check_eq("nofault/fcount", bus.fault_count, 0);
    end
    k_out = k;
  endtask

  // Drive left_q through the activation pipeline (controller in COMPUTE).
  task automatic run_left();
    logic [WORD_SIZE-1:0] hist [$];
    logic [WORD_SIZE-1:0] v;
    int n;
    n = left_q.size();
    hist.push_back('0);
    hist.push_back('0);
    for (int t = 0; t < n + 2; t++) begin
      check_eq("left_in", bus.proxy_left_in, hist[hist.size()-1]);
      check_eq("out_valid", bus.proxy_out_valid, hist[hist.size()-2] != '0);
      v = (t < n) ? left_q[t] : '0;
      bus.rcm_left_in = v;
      hist.push_back(v);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst                = 1'b1;
    bus.STW_complete   = 1'b0;
    bus.STW_result_mat = '0;
    bus.weight_reload  = 1'b0;
    bus.rcm_left_in    = '0;
    randomize_weights();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // No fault: nothing happens.
    run_tile(4'b1111, k);
    reload_and_check("reload_a");

    // Single fault on row 2.
    randomize_weights();
    wmem[2] = 16'h00A5;
    run_tile(4'b1011, k);
    left_q = {16'h0000, 16'h0007, 16'h0000, 16'h0003};
    run_left();
    reload_and_check("reload_b");

    // Two faults, rows 0 and 3.
    randomize_weights();
    run_tile(4'b0110, k);
    reload_and_check("reload_c");

    // Overflow; a further STW in COMPUTE must be ignored.
    randomize_weights();
    run_tile(4'b0000, k);
    bus.STW_complete = 1'b1;
    bus.STW_result_mat = 4'b1110;
    @(negedge clk);
    bus.STW_complete = 1'b0;
    @(negedge clk);
    check_eq("ignore/fcount", bus.fault_count, 4);
    check_eq("ignore/en", bus.proxy_en, 4'b0011);
    check_eq("ignore/matmul", bus.proxy_matmul, 1);
    check_eq("ignore/uncov", bus.uncovered_fault, 1);
    reload_and_check("reload_d");

    // Reload while the first proxy is in LOAD2.
    randomize_weights();
    bus.STW_complete = 1'b1;
    bus.STW_result_mat = 4'b0101;
    @(negedge clk);
    bus.STW_complete = 1'b0;
    @(negedge clk);
    check_eq("l2/idx_sel", bus.rcm_idx_sel, 1);
    @(negedge clk);
    check_eq("l2/busy", bus.busy, 1);
    reload_and_check("reload_load2");
    run_tile(4'b1110, k);
    reload_and_check("reload_e");

    // STW and reload in the same cycle: reload wins.
    bus.STW_complete = 1'b1;
    bus.STW_result_mat = 4'b0000;
    bus.weight_reload = 1'b1;
    @(negedge clk);
    bus.STW_complete = 1'b0;
    bus.weight_reload = 1'b0;
    check_cleared("stw_reload");
    repeat (4) begin
      @(negedge clk);
      check_eq("stw_reload/busy", bus.busy, 0);
      check_eq("stw_reload/matmul", bus.proxy_matmul, 0);
    end

    // Reset in the middle of loading.
    bus.STW_complete = 1'b1;
    bus.STW_result_mat = 4'b0110;
    @(negedge clk);
    bus.STW_complete = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("mid_rst");

    // Random tiles.
    for (int it = 0; it < 24; it++) begin
      randomize_weights();
      run_tile(ROWS'($urandom), k);
      if (k > 0) begin
        left_q.delete();
        for (int i = 0; i < 5; i++)
          left_q.push_back(($urandom_range(0, 1) == 1) ? WORD_SIZE'($urandom) : '0);
        run_left();
      end
      reload_and_check("reload_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end
endmodule
